// File: rtl/seq_detector_1001_moore.sv
// Serial 1-0-0-1 pattern detector (Moore). Flags one cycle after the final '1'
// of the pattern is sampled; OVERLAP selects whether that '1' may begin a new match.
module seq_detector_1001_moore #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  output logic detect
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  // State register; detect is registered from next_state so it tracks state==S4.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S0;
      detect <= 1'b0;
    end else begin
      state  <= next_state;
      detect <= (next_state == S4);
    end
  end

  // Next-state logic; unused encodings fall back to S0.
  always_comb begin
    next_state = S0;
    case (state)
      S0: next_state = in_bit ? S1 : S0;
      S1: next_state = in_bit ? S1 : S2;
      S2: next_state = in_bit ? S1 : S3;
      S3: next_state = in_bit ? S4 : S0;
      S4: begin
        if (in_bit)       next_state = S1;
        else if (OVERLAP) next_state = S2;
        else              next_state = S0;
      end
      default: next_state = S0;
    endcase
  end

endmodule

// File: tb/tb_seq_detector_1001_moore.sv
// Bench for seq_detector_1001_moore: overlapping and non-overlapping instances
// share one stimulus and are compared against an occurrence-search model.
module tb_seq_detector_1001_moore;

  logic clk;
  logic rst;
  logic in_bit;
  logic det_ov;
  logic det_no;

  int checks = 0;
  int errors = 0;

  // Reference model: bit history since last reset, end index of last accepted
  // non-overlapping match, and pulse counters for the directed sequences.
  bit hist[$];
  int last_end_no;
  bit exp_ov;
  bit exp_no;
  int pulses_ov;
  int pulses_no;

  seq_detector_1001_moore #(.OVERLAP(1'b1)) dut_ov (
    .clk(clk), .rst(rst), .in_bit(in_bit), .detect(det_ov)
  );

  seq_detector_1001_moore #(.OVERLAP(1'b0)) dut_no (
    .clk(clk), .rst(rst), .in_bit(in_bit), .detect(det_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input bit b, input bit r);
    int n;
    bit hit;
    if (!r) begin
      hist.delete();
      last_end_no = -1;
      exp_ov = 1'b0;
      exp_no = 1'b0;
    end else begin
      hist.push_back(b);
      n = hist.size();
      hit = (n >= 4) && hist[n-4] && !hist[n-3] && !hist[n-2] && hist[n-1];
      exp_ov = hit;
      exp_no = hit && ((n - 4) > last_end_no);
      if (exp_no) last_end_no = n - 1;
    end
  endtask

  // Drive one bit (and reset level), clock it, then check both instances.
  task automatic step(input bit b, input bit r);
    in_bit = b;
    rst    = r;
    @(posedge clk);
    model_update(b, r);
    @(negedge clk);
    checks++;
    assert (det_ov === exp_ov) else begin
      errors++;
      $error("FAIL detect_ov bit=%0b rst=%0b observed=%b expected=%b", b, r, det_ov, exp_ov);
    end
    checks++;
    assert (det_no === exp_no) else begin
      errors++;
      $error("FAIL detect_no bit=%0b rst=%0b observed=%b expected=%b", b, r, det_no, exp_no);
    end
    if (det_ov === 1'b1) pulses_ov++;
    if (det_no === 1'b1) pulses_no++;
  endtask

  task automatic drive_seq(input bit bits[]);
    foreach (bits[i]) step(bits[i], 1'b1);
  endtask

  task automatic check_pulses(input string tag, input int exp_o, input int exp_n);
    checks++;
    assert (pulses_ov == exp_o) else begin
      errors++;
      $error("FAIL %s pulses_ov observed=%0d expected=%0d", tag, pulses_ov, exp_o);
    end
    checks++;
    assert (pulses_no == exp_n) else begin
      errors++;
      $error("FAIL %s pulses_no observed=%0d expected=%0d", tag, pulses_no, exp_n);
    end
    pulses_ov = 0;
    pulses_no = 0;
  endtask

  initial begin
    bit seq[];
    last_end_no = -1;
    pulses_ov = 0;
    pulses_no = 0;
    rst = 1'b0;
    in_bit = 1'b1;
    @(negedge clk);

    // Reset held two edges with in_bit=1, then 0,0,1 gives nothing.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    seq = '{1'b0, 1'b0, 1'b1};
    drive_seq(seq);
    check_pulses("reset", 0, 0);

    // Basic match.
    step(1'b0, 1'b0);
    seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    drive_seq(seq);
    step(1'b0, 1'b1);
    check_pulses("basic", 1, 1);

    // Overlap stream: 3 pulses overlapping, 2 non-overlapping.
    step(1'b0, 1'b0);
    seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    drive_seq(seq);
    check_pulses("overlap", 3, 2);

    // Near-misses, then a genuine match.
    step(1'b0, 1'b0);
    seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    drive_seq(seq);
    seq = '{1'b1, 1'b1, 1'b0, 1'b1};
    drive_seq(seq);
    check_pulses("near_miss", 0, 0);
    seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    drive_seq(seq);
    check_pulses("after_miss", 1, 1);

    // Reset mid-pattern discards the 1,0,0 prefix.
    step(1'b0, 1'b0);
    seq = '{1'b1, 1'b0, 1'b0};
    drive_seq(seq);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_pulses("mid_reset", 0, 0);
    seq = '{1'b0, 1'b0, 1'b1};
    drive_seq(seq);
    check_pulses("mid_reset_match", 1, 1);

    // Randomized stream biased toward zeros, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 199) != 0);
      step(bit'($urandom_range(0, 99) < 45), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
